// File: rtl/pipe_alu_arbiter.sv
// Two-requester round-robin arbiter in front of a fixed-latency ALU.
// Registers the winning operands toward the ALU and tracks each accepted
// operation with a tag shift register so the result can be routed back.
module pipe_alu_arbiter #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;
    localparam logic [OPW-1:0] OP_IDLE      = 4'hF;
    localparam logic [OPW-1:0] OP_LAST_LEGAL = 4'd4;

    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

    logic           gnt0;
    logic           gnt1;
    logic           accept;
    logic           last_grant;   // 1: requester 1 won the last contention-free or contended grant
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [OPW-1:0] sel_op;
    tag_t           tags [LAT+1];

    // Round-robin grant; nothing is granted while held or in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !hold) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    // Winner operand mux
    always_comb begin
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_op = req0_op;
        if (gnt1) begin
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_op = req1_op;
        end
    end

    // Last-grant pointer moves only on an accepted operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt1;
        end
    end

    // ALU operand registers; opcode parks at idle when nothing is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= OP_IDLE;
        end else if (accept) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
        end else begin
            alu_op <= OP_IDLE;
        end
    end

    // Tag pipeline: stage LAT lines up with the ALU result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i <= LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0].valid <= accept;
            tags[0].id    <= gnt1;
            tags[0].err   <= accept && (sel_op > OP_LAST_LEGAL);
            for (int unsigned i = 1; i <= LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Operations in flight
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            busy = busy | tags[i].valid;
        end
    end

    assign rsp0_valid = tags[LAT].valid & ~tags[LAT].id;
    assign rsp1_valid = tags[LAT].valid &  tags[LAT].id;
    assign rsp_err    = tags[LAT].valid &  tags[LAT].err;
    assign rsp_data   = alu_result;

endmodule

// File: tb/tb_pipe_alu_arbiter.sv
// Bench for pipe_alu_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_pipe_alu_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk;
    logic        reset_n;
    logic        hold;
    logic        r0v, r1v;
    logic        req0_ready, req1_ready;
    logic [15:0] r0a, r0b, r1a, r1b;
    logic [3:0]  r0op, r1op;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    pipe_alu_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold),
        .req0_valid(r0v), .req1_valid(r1v),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
        .req0_op(r0op), .req1_op(r1op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU function: legal ops compute, anything else yields 0
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return 16'(a + b);
            4'd1:    return 16'(a - b);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    // Attached ALU: LAT-cycle pipeline fed from the DUT's registered operands
    logic [15:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_op, alu_a, alu_b);
        for (int i = 1; i < int'(LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    typedef struct {
        int          due;
        bit          id;
        bit          err;
        logic [15:0] data;
    } rsp_t;

    rsp_t        q[$];
    int          cyc = 0;
    int          m_last = 1;
    logic [3:0]  m_op = 4'hF;
    logic [15:0] m_a = '0, m_b = '0;

    always @(negedge clk) begin
        int   g;
        rsp_t e;
        cyc++;
        if (!reset_n) begin
            chk("rst_ready0", 32'(req0_ready), 0);
            chk("rst_ready1", 32'(req1_ready), 0);
            chk("rst_rsp0", 32'(rsp0_valid), 0);
            chk("rst_rsp1", 32'(rsp1_valid), 0);
            chk("rst_err", 32'(rsp_err), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_alu_op", 32'(alu_op), 32'hF);
            chk("rst_alu_a", 32'(alu_a), 0);
            chk("rst_alu_b", 32'(alu_b), 0);
            q.delete();
            m_last = 1;
            m_op = 4'hF;
            m_a = '0;
            m_b = '0;
        end else begin
            g = -1;
            if (!hold) begin
                if (r0v && r1v) g = (m_last == 1) ? 0 : 1;
                else if (r0v)   g = 0;
                else if (r1v)   g = 1;
            end
            chk("ready0", 32'(req0_ready), 32'(g == 0));
            chk("ready1", 32'(req1_ready), 32'(g == 1));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rsp0_valid", 32'(rsp0_valid), 32'(!e.id));
                chk("rsp1_valid", 32'(rsp1_valid), 32'(e.id));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end else begin
                chk("rsp0_idle", 32'(rsp0_valid), 0);
                chk("rsp1_idle", 32'(rsp1_valid), 0);
                chk("err_idle", 32'(rsp_err), 0);
            end
            if (g >= 0) begin
                m_op = (g == 1) ? r1op : r0op;
                m_a  = (g == 1) ? r1a : r0a;
                m_b  = (g == 1) ? r1b : r0b;
                e.due  = cyc + int'(LAT) + 1;
                e.id   = (g == 1);
                e.err  = (m_op > 4'd4);
                e.data = alu_ref(m_op, m_a, m_b);
                q.push_back(e);
                m_last = g;
            end else begin
                m_op = 4'hF;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0v = 0; r1v = 0; hold = 0;
    endtask

    task automatic set0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        r0v = 1; r0op = op; r0a = a; r0b = b;
    endtask

    task automatic set1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        r1v = 1; r1op = op; r1a = a; r1b = b;
    endtask

    task automatic do_reset();
        reset_n = 0; idle();
        @(negedge clk); next();
        @(negedge clk); next();
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0; hold = 0; r0v = 0; r1v = 0;
        r0a = '0; r0b = '0; r1a = '0; r1b = '0; r0op = '0; r1op = '0;
        @(negedge clk); next();
        @(negedge clk); next();
        reset_n = 1;

        // Single ADD, 4-cycle response
        set0(4'd0, 16'h0005, 16'h0003);
        @(negedge clk);
        chk("p_add_ready0", 32'(req0_ready), 1);
        chk("p_add_ready1", 32'(req1_ready), 0);
        next(); idle();
        @(negedge clk); chk("p_add_alu_op", 32'(alu_op), 0);
        next(); next();
        @(negedge clk); chk("p_add_early", 32'(rsp0_valid), 0);
        next();
        @(negedge clk);
        chk("p_add_rsp0", 32'(rsp0_valid), 1);
        chk("p_add_data", 32'(rsp_data), 32'h0008);
        next();
        @(negedge clk); chk("p_add_once", 32'(rsp0_valid), 0);
        next();

        // Contention after reset alternates, starting with requester 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set0(4'd1, 16'h0010, 16'h0001);
            set1(4'd4, 16'hFFFF, 16'h00FF);
            @(negedge clk); chk("p_rr_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            next();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p_rr_rsp0", 32'(rsp0_valid), 32'(i % 2 == 0));
            chk("p_rr_rsp1", 32'(rsp1_valid), 32'(i % 2 == 1));
            chk("p_rr_data", 32'(rsp_data), (i % 2 == 0) ? 32'h000F : 32'hFF00);
            next();
        end

        // Illegal opcode is accepted and returns an error response
        set1(4'h9, 16'h1234, 16'h5678);
        @(negedge clk); chk("p_ill_ready1", 32'(req1_ready), 1);
        next(); idle();
        next(); next(); next();
        @(negedge clk);
        chk("p_ill_rsp1", 32'(rsp1_valid), 1);
        chk("p_ill_err", 32'(rsp_err), 1);
        chk("p_ill_data", 32'(rsp_data), 0);
        next(); next();

        // Hold blocks issue while the in-flight op completes
        set0(4'd2, 16'h0F0F, 16'h00FF);
        next();
        for (int i = 1; i <= 3; i++) begin
            hold = 1; set0(4'd0, 16'h1, 16'h1); set1(4'd0, 16'h2, 16'h2);
            @(negedge clk);
            chk("p_hold_ready0", 32'(req0_ready), 0);
            chk("p_hold_ready1", 32'(req1_ready), 0);
            chk("p_hold_alu_op", 32'(alu_op), (i == 1) ? 32'd2 : 32'hF);
            next();
        end
        idle();
        @(negedge clk);
        chk("p_hold_rsp0", 32'(rsp0_valid), 1);
        chk("p_hold_data", 32'(rsp_data), 32'h000F);
        next();
        @(negedge clk); chk("p_hold_busy", 32'(busy), 0);
        next();

        // Reset mid-flight discards pending responses
        set0(4'd0, 16'h1, 16'h2);
        next(); idle();
        set1(4'd3, 16'h3, 16'h4);
        next();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("p_rst_rsp", 32'(rsp0_valid | rsp1_valid), 0);
            chk("p_rst_busy", 32'(busy), 0);
            next();
        end
        set0(4'd0, 16'h1, 16'h1); set1(4'd0, 16'h2, 16'h2);
        @(negedge clk); chk("p_rst_grant0", 32'(req0_ready), 1);
        next(); idle();
        next(); next(); next(); next();

        // ADD wraps without carry
        set1(4'd0, 16'hFFFF, 16'h0001);
        next(); idle();
        next(); next(); next();
        @(negedge clk);
        chk("p_wrap_rsp1", 32'(rsp1_valid), 1);
        chk("p_wrap_data", 32'(rsp_data), 0);
        chk("p_wrap_err", 32'(rsp_err), 0);
        next();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                r0v  = ($urandom_range(0, 99) < 60);
                r1v  = ($urandom_range(0, 99) < 60);
                hold = ($urandom_range(0, 99) < 15);
                r0op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                r1op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                r0a = 16'($urandom); r0b = 16'($urandom);
                r1a = 16'($urandom); r1b = 16'($urandom);
                @(negedge clk);
                next();
            end
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            next();
        end
        @(negedge clk);
        chk("drain_queue", 32'(q.size()), 0);
        chk("drain_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
